taylor_trig_accel: RTL

//  Parametrised successor of the fixed 16-bit cosine accelerator. Computes cos(x) or sin(x) as an
//  N-term Taylor sum in signed fixed point, one term per clock, on one shared iterative datapath.

---
 rtl/taylor_trig_accel_pkg.sv | 32 +++
 rtl/taylor_trig_accel_if.sv | 16 +
 rtl/taylor_trig_accel_coef_rom.sv | 24 ++
 rtl/taylor_trig_accel.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/taylor_trig_accel_pkg.sv
// Shared types, mode encodings, saturation limits and coefficient generator
// for the iterative Taylor-series trig accelerator.
package taylor_trig_accel_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SQUARE,
        S_ITER,
        S_DONE
    } state_t;

    localparam logic MODE_COS = 1'b0;
    localparam logic MODE_SIN = 1'b1;

    function automatic longint satHi(input int w);
        return (longint'(1) <<< (w - 1)) - 1;
    endfunction

    function automatic longint satLo(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

    // Ratio between consecutive Taylor terms, rounded to nearest in unsigned Q0.cw.
    function automatic longint coefCalc(input logic m, input int k, input int cw);
        longint d;
        if (m == MODE_COS) d = longint'((2 * k + 1) * (2 * k + 2));
        else               d = longint'((2 * k + 2) * (2 * k + 3));
        return ((longint'(1) <<< cw) + d / 2) / d;
    endfunction

endpackage

// File: rtl/taylor_trig_accel_if.sv
// Host start/done interface of the trig accelerator.
interface taylor_trig_accel_if #(
    parameter int DW = 16,
    parameter int NW = 8
);
    logic          start;
    logic          mode;
    logic [DW-1:0] x_bus;
    logic [NW-1:0] n_bus;
    logic          busy;
    logic          done;
    logic [DW-1:0] out_bus;

    modport master (output start, mode, x_bus, n_bus, input busy, done, out_bus);
    modport slave  (input start, mode, x_bus, n_bus, output busy, done, out_bus);
endinterface

// File: rtl/taylor_trig_accel_coef_rom.sv
// Combinational table of term-to-term ratios for cos and sin, built at elaboration.
module trig_coef_rom
    import taylor_trig_accel_pkg::*;
#(
    parameter int MAX_TERMS = 8,
    parameter int CW        = 16,
    parameter int IW        = $clog2(MAX_TERMS)
) (
    input  logic          mode_i,
    input  logic [IW-1:0] index_i,
    output logic [CW-1:0] coef_o
);

    logic [CW-1:0] coefTable [2][MAX_TERMS];

    for (genvar m = 0; m < 2; m++) begin : g_mode
        for (genvar k = 0; k < MAX_TERMS; k++) begin : g_term
            assign coefTable[m][k] = CW'(coefCalc((m == 1) ? MODE_SIN : MODE_COS, k, CW));
        end
    end

    assign coef_o = coefTable[mode_i][index_i];

endmodule

// File: rtl/taylor_trig_accel.sv
// Iterative cos/sin Taylor accelerator: one term per clock on a shared multiplier
// path, saturating accumulator, busy/done handshake towards the host.
module taylor_trig_accel
    import taylor_trig_accel_pkg::*;
#(
    parameter int DW        = 16,
    parameter int FRAC      = 8,
    parameter int NW        = 8,
    parameter int MAX_TERMS = 8,
    parameter int CW        = 16
) (
    input logic                clk,
    input logic                rst_n,
    taylor_trig_accel_if.slave host
);

    localparam int IW = $clog2(MAX_TERMS);
    localparam int XW = 2 * DW;
    // Term register carries FRAC extra bits so large |x| overflows into the accumulator clamp.
    localparam int TW = 2 * DW + FRAC;
    localparam int AW = DW + 2;
    localparam int SW = TW + 1;
    localparam int PW = TW + CW + 1;

    localparam logic signed [SW-1:0] ACC_HI = SW'(satHi(AW));
    localparam logic signed [SW-1:0] ACC_LO = SW'(satLo(AW));
    localparam logic signed [AW-1:0] OUT_HI = AW'(satHi(DW));
    localparam logic signed [AW-1:0] OUT_LO = AW'(satLo(DW));
    localparam logic signed [TW-1:0] ONE    = TW'(longint'(1) <<< FRAC);

    state_t state_q, state_d;
    logic latchEn, loadEn, initEn, iterEn, finishEn;

    logic signed [DW-1:0] x_q;
    logic signed [XW-1:0] x2_q;
    logic signed [TW-1:0] term_q;
    logic signed [AW-1:0] acc_q;
    logic        [NW-1:0] k_q, nc_q;
    logic                 mode_q, done_q;
    logic        [DW-1:0] out_q;

    logic        [NW-1:0] nClamp;
    logic        [CW-1:0] coef;
    logic signed [CW:0]   coefS;
    logic signed [XW-1:0] xProd;
    logic signed [TW+XW-1:0] termProd;
    logic signed [TW-1:0] termScaled, termNext, termInit;
    logic signed [PW-1:0] coefProd, negProd;
    logic signed [SW-1:0] accSum;
    logic signed [AW-1:0] accNext;
    logic signed [DW-1:0] outSat;

    trig_coef_rom #(.MAX_TERMS(MAX_TERMS), .CW(CW), .IW(IW)) u_rom (
        .mode_i (mode_q),
        .index_i(IW'(k_q - NW'(1))),
        .coef_o (coef)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (host.start) state_d = S_LOAD;
            S_LOAD:   state_d = (nc_q == '0) ? S_DONE : S_SQUARE;
            S_SQUARE: state_d = (nc_q <= NW'(1)) ? S_DONE : S_ITER;
            S_ITER:   if (k_q + NW'(1) == nc_q) state_d = S_DONE;
            S_DONE:   state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        latchEn  = 1'b0;
        loadEn   = 1'b0;
        initEn   = 1'b0;
        iterEn   = 1'b0;
        finishEn = 1'b0;
        case (state_q)
            S_IDLE:   latchEn  = host.start;
            S_LOAD:   loadEn   = 1'b1;
            S_SQUARE: initEn   = 1'b1;
            S_ITER:   iterEn   = 1'b1;
            S_DONE:   finishEn = 1'b1;
            default:  ;
        endcase
    end

    assign nClamp     = (host.n_bus > NW'(MAX_TERMS)) ? NW'(MAX_TERMS) : host.n_bus;
    assign xProd      = XW'(x_q) * XW'(x_q);
    assign termInit   = (mode_q == MODE_SIN) ? TW'(x_q) : ONE;
    assign termProd   = (TW + XW)'(term_q) * (TW + XW)'(x2_q);
    assign termScaled = TW'(termProd >>> FRAC);
    assign coefS      = {1'b0, coef};
    assign coefProd   = PW'(termScaled) * PW'(coefS);
    assign negProd    = -coefProd;
    assign termNext   = TW'(negProd >>> CW);
    assign accSum     = SW'(termNext) + SW'(acc_q);
    assign accNext    = (accSum > ACC_HI) ? AW'(ACC_HI) :
                        (accSum < ACC_LO) ? AW'(ACC_LO) : AW'(accSum);
    assign outSat     = (acc_q > OUT_HI) ? DW'(OUT_HI) :
                        (acc_q < OUT_LO) ? DW'(OUT_LO) : DW'(acc_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_q    <= '0;
            x2_q   <= '0;
            term_q <= '0;
            acc_q  <= '0;
            k_q    <= '0;
            nc_q   <= '0;
            mode_q <= MODE_COS;
            done_q <= 1'b0;
            out_q  <= '0;
        end else begin
            done_q <= finishEn;
            if (latchEn) begin
                x_q    <= host.x_bus;
                mode_q <= host.mode;
                nc_q   <= nClamp;
                term_q <= '0;
                acc_q  <= '0;
                k_q    <= '0;
            end
            if (loadEn) x2_q <= xProd >>> FRAC;
            if (initEn) begin
                term_q <= termInit;
                acc_q  <= AW'(termInit);
                k_q    <= NW'(1);
            end
            if (iterEn) begin
                term_q <= termNext;
                acc_q  <= accNext;
                k_q    <= k_q + NW'(1);
            end
            if (finishEn) out_q <= outSat;
        end
    end

    assign host.busy    = (state_q != S_IDLE) || done_q;
    assign host.done    = done_q;
    assign host.out_bus = out_q;

endmodule
